// File: rtl/mult_ctrl.sv
// mult_ctrl: iterative shift-add multiplier controller, one multiplier bit per clock.
// Signed operand support is compiled in only when MULT_SIGNED_EN is defined.
module mult_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk0,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic             sgn,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] mcand_q;
   logic [PW-1:0]    acc_q;
   logic             neg_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic [WIDTH-1:0] mag_a_c;
   logic [WIDTH-1:0] mag_b_c;
   logic             neg_c;
   logic [WIDTH:0]   sum_c;
   logic [PW-1:0]    acc_d;
   logic [PW-1:0]    result_c;
   logic             last_c;
   logic             accept_c;

   // Operand magnitudes and result sign, evaluated at capture time
`ifdef MULT_SIGNED_EN
   always_comb begin
      mag_a_c = op_a;
      mag_b_c = op_b;
      neg_c   = 1'b0;
      if (sgn) begin
         if (op_a[WIDTH-1]) mag_a_c = ~op_a + WIDTH'(1);
         if (op_b[WIDTH-1]) mag_b_c = ~op_b + WIDTH'(1);
         neg_c = op_a[WIDTH-1] ^ op_b[WIDTH-1];
      end
   end
`else
   logic unused_sgn;
   assign unused_sgn = sgn;
   assign mag_a_c    = op_a;
   assign mag_b_c    = op_b;
   assign neg_c      = 1'b0;
`endif

   // acc_q holds {partial sum, multiplier bits not yet consumed}; one step per edge
   always_comb begin
      sum_c    = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
      acc_d    = {sum_c, acc_q[WIDTH-1:1]};
      result_c = neg_q ? (~acc_d + PW'(1)) : acc_d;
      last_c   = (cnt_q == CNT_W'(WIDTH - 1));
      accept_c = start & ~flush;
   end

   always_ff @(posedge clk0 or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_c) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  mcand_q <= mag_a_c;
                  acc_q   <= {WIDTH'(0), mag_b_c};
                  neg_q   <= neg_c;
               end
            end
            RUN: begin
               if (flush) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (last_c) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     hi_q    <= result_c[PW-1:WIDTH];
                     lo_q    <= result_c[WIDTH-1:0];
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Stall also covers the accept cycle, before busy rises
   assign stall = busy_q | (start & (state_q == IDLE));
   assign busy  = busy_q;
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: directed multiplies checked against a cycle-level product model.
module tb_mult_ctrl;

   localparam int unsigned W = 32;
`ifdef MULT_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic         clk0  = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic         sgn   = 1'b0;
   logic [W-1:0] op_a  = '0;
   logic [W-1:0] op_b  = '0;
   logic         busy;
   logic         stall;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;

   mult_ctrl #(.WIDTH(W)) dut (
      .clk0  (clk0),
      .reset (reset),
      .start (start),
      .flush (flush),
      .sgn   (sgn),
      .op_a  (op_a),
      .op_b  (op_b),
      .busy  (busy),
      .stall (stall),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk0 = ~clk0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      logic [63:0] xa;
      logic [63:0] xb;
      xa = {32'b0, a};
      xb = {32'b0, b};
      if (s && SIGNED_EN) begin
         xa = {{32{a[31]}}, a};
         xb = {{32{b[31]}}, b};
      end
      return xa * xb;
   endfunction

   // Reference: RUN lasts 32 cycles, then one DONE cycle carrying the product
   int          m_remain = 0;
   bit          m_done   = 1'b0;
   logic [31:0] m_hi     = '0;
   logic [31:0] m_lo     = '0;
   logic [63:0] m_pend   = '0;

   always @(posedge clk0 or negedge reset) begin
      if (!reset) begin
         m_remain = 0;
         m_done   = 1'b0;
         m_hi     = '0;
         m_lo     = '0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_remain > 0) begin
         if (flush) m_remain = 0;
         else begin
            m_remain--;
            if (m_remain == 0) begin
               m_done = 1'b1;
               {m_hi, m_lo} = m_pend;
            end
         end
      end else if (start && !flush) begin
         m_remain = 32;
         m_pend   = product(op_a, op_b, sgn);
      end
   end

   always @(negedge clk0) begin
      if (checking) begin
         check("busy",  64'(busy),  64'(m_remain > 0));
         check("stall", 64'(stall), 64'((m_remain > 0) || (start && !m_done)));
         check("done",  64'(done),  64'(m_done));
         check("hi",    64'(hi),    64'(m_hi));
         check("lo",    64'(lo),    64'(m_lo));
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eh, input logic [31:0] el, input string tag,
                         input bit poke_done);
      int cyc = 0;
      op_a  = a;
      op_b  = b;
      sgn   = s;
      start = 1'b1;
      @(posedge clk0);
      #1 start = 1'b0;
      while (cyc < 40) begin
         @(posedge clk0);
         cyc++;
         #1;
         if (done) break;
      end
      check({tag, "_latency"}, 64'(cyc), 64'd32);
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      if (poke_done) start = 1'b1;
      @(posedge clk0);
      #1 start = 1'b0;
      check({tag, "_done_clear"}, 64'(done), 64'd0);
      if (poke_done) check({tag, "_start_in_done_ignored"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      repeat (3) @(posedge clk0);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi",   64'(hi),   64'd0);
      check("rst_lo",   64'(lo),   64'd0);
      checking = 1'b1;
      @(posedge clk0);
      #1 reset = 1'b1;

      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, "ones", 1'b0);
      run_op(32'hFFFF_FFFD, 32'd5, 1'b1,
             SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0004, 32'hFFFF_FFF1, "neg3x5", 1'b0);
      run_op(32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1,
             SIGNED_EN ? 32'h0000_0000 : 32'hFFFF_FFFB, 32'h0000_0006, "neg2xneg3", 1'b0);
      run_op(32'd0, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0, "zero", 1'b0);
      run_op(32'd6, 32'd7, 1'b0, 32'd0, 32'h0000_002A, "basic", 1'b1);

      // Abort on RUN cycle 10; previous 6x7 result must survive
      op_a  = 32'd9;
      op_b  = 32'd9;
      sgn   = 1'b0;
      start = 1'b1;
      @(posedge clk0);
      #1 start = 1'b0;
      repeat (9) @(posedge clk0);
      #1 flush = 1'b1;
      @(posedge clk0);
      #1 flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_done", 64'(done), 64'd0);
      check("flush_hi",   64'(hi),   64'd0);
      check("flush_lo",   64'(lo),   64'h2A);
      run_op(32'd3, 32'd4, 1'b0, 32'd0, 32'd12, "after_flush", 1'b0);

      // start together with flush in IDLE is refused
      start = 1'b1;
      flush = 1'b1;
      @(posedge clk0);
      #1;
      start = 1'b0;
      flush = 1'b0;
      check("idle_flush_start_busy", 64'(busy), 64'd0);
      @(posedge clk0);
      #1 check("idle_flush_start_busy2", 64'(busy), 64'd0);
      run_op(32'd11, 32'd13, 1'b0, 32'd0, 32'd143, "after_refuse", 1'b0);

      // Asynchronous reset on RUN cycle 15, between edges
      op_a  = 32'd100;
      op_b  = 32'd200;
      start = 1'b1;
      @(posedge clk0);
      #1 start = 1'b0;
      repeat (14) @(posedge clk0);
      #2 reset = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_hi",   64'(hi),   64'd0);
      check("midrst_lo",   64'(lo),   64'd0);
      repeat (2) @(posedge clk0);
      #1 reset = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk0);
         #1;
         if (done) seen++;
      end
      check("midrst_no_done", 64'(seen), 64'd0);
      run_op(32'd6, 32'd7, 1'b0, 32'd0, 32'h0000_002A, "after_reset", 1'b0);

      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, giving the operand width in bits (legal range 4..32).
REQ-002 SHALL provide port clk0  input  1  the single clock; every register updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 SHALL provide port start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL provide port flush  input  1  synchronous abort of an in-flight multiply.
REQ-006 SHALL provide port sgn  input  1  operands are two's-complement when high; sampled with start.
REQ-007 SHALL provide port op_a  input  WIDTH  multiplicand, sampled with start.
REQ-008 SHALL provide port op_b  input  WIDTH  multiplier, sampled with start.
REQ-009 SHALL provide port busy  output  1  high while in RUN.
REQ-010 SHALL provide port stall  output  1  CPU stall request; equals busy OR (start AND state==IDLE), combinational.
REQ-011 SHALL provide port done  output  1  one-cycle pulse: the result is valid.
REQ-012 SHALL provide port hi  output  WIDTH  upper half of the 2*WIDTH product.
REQ-013 SHALL provide port lo  output  WIDTH  lower half of the 2*WIDTH product.

Function
REQ-014 SHALL implement three states: IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE with start=1 at edge E0, capture op_a, op_b and sgn, clear the accumulator and bit counter, and enter RUN.
REQ-016 SHALL perform iterative shift-add in RUN, one multiplier bit per edge, LSB first, with a log2(WIDTH)+1-bit counter.
REQ-017 SHALL leave RUN for DONE at the edge that processes bit WIDTH-1, which is edge E_WIDTH.
REQ-018 SHALL hold done high for exactly the one cycle spent in DONE, WIDTH cycles after E0, with hi and lo already updated.
REQ-019 SHALL always move DONE to IDLE on the next edge.
REQ-020 SHALL not allow back-to-back operations: a start seen in DONE is ignored, so the earliest next accept is from IDLE.
REQ-021 SHALL ignore start while in RUN or DONE.
REQ-022 SHALL let flush=1 in RUN return the block to IDLE on the next edge, with done staying low and hi/lo keeping their previous values.
REQ-023 SHALL treat flush in IDLE or DONE as no effect.
REQ-024 SHALL give flush priority over start when both are high in the same cycle.
REQ-025 SHALL hold hi and lo stable from DONE until the next DONE; they change only on the edge that enters DONE.
REQ-026 SHALL compute the full 2*WIDTH-bit product with no truncation, including when operands are zero or all-ones.
REQ-027 SHALL keep busy=0 and done=0 in IDLE.

Reset
REQ-028 SHALL, while reset=0, immediately force state=IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, asynchronously and independent of clk0.
REQ-029 SHALL abandon any multiply in progress when reset is asserted mid-RUN, and SHALL not pulse done on release.
REQ-030 SHALL first act on start at the first rising edge of clk0 after reset returns high.

Configuration
REQ-031 SHALL support macro MULT_SIGNED_EN; when defined, signed mode is compiled in.
REQ-032 SHALL, when MULT_SIGNED_EN is defined and sgn=1, convert operands to magnitudes at capture and two's-complement negate the 2*WIDTH result when entering DONE if the operand signs differ; latency is unchanged.
REQ-033 SHALL, when MULT_SIGNED_EN is undefined, keep the sgn port present but ignore it, so all multiplies are unsigned.

Verification
REQ-034 SHALL cover a basic unsigned multiply: WIDTH=32, op_a=6, op_b=7, start pulsed at E0 -> busy for 32 cycles, done pulsed once at cycle 32, hi=0x00000000, lo=0x0000002A, stall high from the start cycle through the last RUN cycle.
REQ-035 SHALL cover an all-ones multiply with sgn=0: op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 SHALL cover signed operands: op_a=0xFFFFFFFD (-3), op_b=5, sgn=1 -> with MULT_SIGNED_EN, hi=0xFFFFFFFF and lo=0xFFFFFFF1; without it, hi=0x00000004 and lo=0xFFFFFFF1.
REQ-037 SHALL cover flush: flush pulsed on cycle 10 of RUN after a prior 6x7 result -> IDLE next edge, done never pulses, hi/lo still 0x0/0x2A, a new start is accepted on the following cycle.
REQ-038 SHALL cover reset mid-RUN: reset driven low at cycle 15 of RUN, between clock edges -> busy, hi and lo read 0 before the next edge, and no done pulse after release.
REQ-039 SHALL cover start and flush together in IDLE: start=1 with flush=1 -> operation not accepted, busy stays 0; then start alone -> normal 32-cycle completion.
